fbuf_scanout: RTL

Video scanout stage downstream of the AXI4-Lite GPU. It reads the 8-bit RGB332 framebuffer BRAM through the BRAM's read port, generates raster timing (default 640x480@60), and emits pixel-aligned RGB888, data-enable and sync signals to the video encoder (DVI/HDMI TX). It runs entirely in the pixel clock domain; the GPU writes the other BRAM port.

---
 rtl/fbuf_scanout.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fbuf_scanout.sv
// fbuf_scanout: raster scanout from an RGB332 framebuffer BRAM.
// Generates raster timing, reads the framebuffer through the BRAM read port
// and drives pixel-aligned RGB888, data enable and syncs to a video encoder.
//
// Ports:
//   vid_aclk        pixel clock (single clock)
//   vid_areset      synchronous reset, active high
//   enable          scanout enable, acted on only at frame boundaries
//   fbuf_en_rd      BRAM read enable (active pixels only)
//   fbuf_addr       BRAM read address (linear pixel index)
//   fbuf_data       BRAM read data, BRAM_LATENCY cycles after the address
//   vid_hsync       horizontal sync (active level HSYNC_POL)
//   vid_vsync       vertical sync (active level VSYNC_POL)
//   vid_de          data enable
//   vid_rgb         {R,G,B} 8 bits each, zero outside vid_de
//   vid_frame_start one-cycle pulse with pixel (0,0)
module fbuf_scanout #(
  parameter int FBUF_ADDR_WIDTH = 19,
  parameter int FBUF_DATA_WIDTH = 8,
  parameter int BRAM_LATENCY    = 1,
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int HSYNC_POL       = 0,
  parameter int VSYNC_POL       = 0
) (
  input  logic                       vid_aclk,
  input  logic                       vid_areset,
  input  logic                       enable,
  output logic                       fbuf_en_rd,
  output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
  input  logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
  output logic                       vid_hsync,
  output logic                       vid_vsync,
  output logic                       vid_de,
  output logic [23:0]                vid_rgb,
  output logic                       vid_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int L       = BRAM_LATENCY + 1;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic          HS_ON  = (HSYNC_POL != 0);
  localparam logic          VS_ON  = (VSYNC_POL != 0);

  // Elaboration-time sanity checks.
  if (FBUF_DATA_WIDTH != 8) begin : g_chk_dw
    $error("fbuf_scanout: only 8-bit RGB332 framebuffer words are supported");
  end
  if (BRAM_LATENCY < 1 || BRAM_LATENCY > 2) begin : g_chk_lat
    $error("fbuf_scanout: BRAM_LATENCY must be 1 or 2");
  end
  if ((longint'(H_ACTIVE) * longint'(V_ACTIVE)) > (longint'(1) << FBUF_ADDR_WIDTH)) begin : g_chk_aw
    $error("fbuf_scanout: framebuffer does not fit FBUF_ADDR_WIDTH");
  end

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } ctl_t;

  state_t                     state_q, state_d;
  logic [HW-1:0]              h_q, h_d;
  logic [VW-1:0]              v_q, v_d;
  logic [FBUF_ADDR_WIDTH-1:0] lin_q, lin_d;   // address of the next active pixel
  logic [FBUF_ADDR_WIDTH-1:0] last_q, last_d; // last address presented
  ctl_t                       ctl_d;
  ctl_t                       ctl_q [1:L];    // ctl_q[k]: control of position k cycles ago
  logic [23:0]                rgb_q;
  logic                       run, active;

  function automatic logic [23:0] rgb332(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], {4{d[1:0]}}};
  endfunction

  assign run    = (state_q == RUN);
  assign active = run && (h_q < H_ACT) && (v_q < V_ACT);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    lin_d   = lin_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        h_d    = '0;
        v_d    = '0;
        lin_d  = '0;
        last_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (active) begin
          lin_d  = lin_q + 1'b1;
          last_d = lin_q;
        end
        if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            // Frame boundary: the only place enable is honoured.
            v_d   = '0;
            lin_d = '0;
            if (!enable) state_d = IDLE;
          end else begin
            v_d = v_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctl_d    = '0;
    ctl_d.de = active;
    ctl_d.hs = run && (h_q >= HS_BEG) && (h_q < HS_END);
    ctl_d.vs = run && (v_q >= VS_BEG) && (v_q < VS_END);
    ctl_d.fs = run && (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge vid_aclk) begin
    if (vid_areset) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      lin_q   <= '0;
      last_q  <= '0;
      for (int k = 1; k <= L; k++) ctl_q[k] <= '0;
      rgb_q   <= '0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      lin_q    <= lin_d;
      last_q   <= last_d;
      ctl_q[1] <= ctl_d;
      for (int k = 2; k <= L; k++) ctl_q[k] <= ctl_q[k-1];
      // fbuf_data now belongs to the position issued BRAM_LATENCY cycles ago.
      rgb_q    <= ctl_q[BRAM_LATENCY].de ? rgb332(fbuf_data[7:0]) : 24'h0;
    end
  end

  assign fbuf_en_rd      = active;
  assign fbuf_addr       = run ? (active ? lin_q : last_q) : '0;
  assign vid_de          = ctl_q[L].de;
  assign vid_hsync       = ctl_q[L].hs ? HS_ON : ~HS_ON;
  assign vid_vsync       = ctl_q[L].vs ? VS_ON : ~VS_ON;
  assign vid_frame_start = ctl_q[L].fs;
  assign vid_rgb         = rgb_q;

endmodule
